// File: rtl/restoring_divider_pkg.sv
// restoring_divider_pkg: FSM state encoding and counter sizing shared by the divider
package restoring_divider_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/restoring_divider_subtractor.sv
// restoring_divider_subtractor: ripple-borrow subtractor built as a - b = a + ~b + 1
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a_i(a_i[i]), .b_i(~b_i[i]), .c_i(c[i]), .s_o(diff_o[i]), .c_o(c[i+1]));
  end
  assign borrow_o = ~c[WIDTH];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned divider, one quotient bit per cycle by trial subtraction
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quot_q, div_q, rem_d, quot_d;
  logic [WIDTH:0]   diff;
  logic             borrow, unused_msb;
  ripple_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a_i({rem_q, quot_q[WIDTH-1]}),
    .b_i({1'b0, div_q}),
    .diff_o(diff),
    .borrow_o(borrow)
  );
  // the partial remainder stays below the divisor, so the difference MSB carries no information
  assign unused_msb = diff[WIDTH];
  assign rem_d  = borrow ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : diff[WIDTH-1:0];
  assign quot_d = {quot_q[WIDTH-2:0], ~borrow};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      div_q         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          o_busy        <= 1'b1;
          o_div_by_zero <= (i_divisor == '0);
          div_q         <= i_divisor;
          rem_q         <= '0;
          quot_q        <= i_dividend;
          cnt_q         <= CW'(WIDTH - 1);
          if (i_divisor == '0) begin
            state_q     <= S_DONE;
            o_done      <= 1'b1;
            o_quotient  <= '1;
            o_remainder <= i_dividend;
          end else begin
            state_q     <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            o_done      <= 1'b1;
            o_quotient  <= quot_d;
            o_remainder <= rem_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: randomized scoreboard bench comparing against integer / and %
module tb_restoring_divider;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, dbz;
  logic [W-1:0] quot, rem;
  int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, n_acc = 0;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;
  exp_t sb[$];

  restoring_divider #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done), .o_quotient(quot), .o_remainder(rem), .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected no pending result", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quot), 32'(e.q));
        chk("remainder", 32'(rem), 32'(e.r));
        chk("div_by_zero", 32'(dbz), 32'(e.z));
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ign_at);
    exp_t e;
    int d0, k;
    e.q   = (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    e.r   = (b == 0) ? a : W'(int'(a) % int'(b));
    e.z   = (b == 0);
    e.due = cyc + ((b == 0) ? 1 : W + 1);
    sb.push_back(e);
    n_acc++;
    d0 = done_cnt;
    start = 1'b1; dividend = a; divisor = b;
    step;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (ign_at > 0) begin
      repeat (ign_at - 1) step;
      start = 1'b1; dividend = 8'd1; divisor = 8'd1;
      step;
      start = 1'b0;
    end
    k = 0;
    while (done_cnt == d0 && k < 4 * W) begin
      step;
      k++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'(done_cnt), 32'(d0 + 1));
    chk("busy_idle_after_done", 32'(busy), 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    step; step;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    step;
    run_op(8'd100, 8'd7, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'd0, 8'd3, 0);
    run_op(8'd42, 8'd0, 0);
    run_op(8'd9, 8'd3, 0);
    run_op(8'd200, 8'd13, 4);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step;
    start = 1'b0;
    repeat (4) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quot", 32'(quot), 32'd0);
    chk("midrst_rem", 32'(rem), 32'd0);
    chk("midrst_dbz", 32'(dbz), 32'd0);
    repeat (2 * W) step;
    run_op(8'd50, 8'd5, 0);
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = pick();
      run_op(a, b, (b != 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(2, W)) : 0);
      repeat ($urandom_range(0, 2)) step;
    end
    repeat (4) step;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(n_acc));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
